// File: rtl/alu_packet_pkg.sv
// Shared types and constants for the byte-stream ALU packet engine.
package alu_packet_pkg;

   typedef enum logic [3:0] {
      S_OP,
      S_RSV,
      S_LEN_LO,
      S_LEN_HI,
      S_ECHO,
      S_OPERAND,
      S_MUL_WAIT,
      S_TX,
      S_DRAIN
   } state_t;

   localparam logic [7:0] OP_ECHO = 8'hEC;
   localparam logic [7:0] OP_ADD  = 8'hAD;
   localparam logic [7:0] OP_MUL  = 8'h88;

   localparam logic [1:0] ERR_NONE   = 2'd0;
   localparam logic [1:0] ERR_OPCODE = 2'd1;
   localparam logic [1:0] ERR_LEN    = 2'd2;

   localparam logic [15:0] HDR_LEN = 16'd4;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier; one partial product per cycle, the first one
// taken in the start cycle, so done_o pulses OPERAND_W cycles after start_i.
module alu_mul_iter #(
   parameter int unsigned OPERAND_W = 32
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 start_i,
   input  logic [OPERAND_W-1:0] a_i,
   input  logic [OPERAND_W-1:0] b_i,
   output logic                 done_o,
   output logic [OPERAND_W-1:0] p_o
);

   localparam int unsigned CNT_W = $clog2(OPERAND_W) + 1;

   logic [OPERAND_W-1:0] a_q, b_q, p_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 run_q, done_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         a_q    <= '0;
         b_q    <= '0;
         p_q    <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start_i) begin
            p_q   <= b_i[0] ? a_i : '0;
            a_q   <= a_i << 1;
            b_q   <= b_i >> 1;
            cnt_q <= CNT_W'(1);
            run_q <= 1'b1;
         end else if (run_q) begin
            if (b_q[0]) p_q <= p_q + a_q;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(OPERAND_W - 1)) begin
               run_q  <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign done_o = done_q;
   assign p_o    = p_q;

endmodule

// File: rtl/alu_packet_engine.sv
// Packet-framed byte-stream ALU: echoes payload or reduces it as little-endian operands
// (sum or product) and streams the OPERAND_W-bit result back LSB first.
module alu_packet_engine
   import alu_packet_pkg::*;
#(
   parameter int unsigned OPERAND_W = 32
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready,
   output logic       busy_o,
   output logic       err_o,
   output logic [1:0] err_code_o
);

   localparam int unsigned NB = OPERAND_W / 8;

   state_t               state_q, state_d, hdr_next;
   logic [7:0]           opcode_q, len_lo_q, out_data_q;
   logic [15:0]          cnt_q, len, payload;
   logic [3:0]           byte_idx_q, tx_idx_q;
   logic [OPERAND_W-1:0] op_q, op_asm, acc_q, mul_p;
   logic [6:0]           op_sh, tx_sh;
   logic                 first_q, out_valid_q, err_q;
   logic [1:0]           err_code_q, hdr_err;
   logic                 s_fire, tx_fire, op_last_byte, pay_last, is_mul;
   logic                 mul_start, mul_done;

   assign s_fire       = s_axis_tvalid && s_axis_tready;
   assign len          = {s_axis_tdata, len_lo_q};
   assign payload      = len - HDR_LEN;
   assign pay_last     = (cnt_q == 16'd1);
   assign op_last_byte = (byte_idx_q == 4'(NB - 1));
   assign is_mul       = (opcode_q == OP_MUL);
   assign op_sh        = {byte_idx_q, 3'b000};
   assign tx_sh        = {tx_idx_q, 3'b000};
   assign op_asm       = (op_q & ~(OPERAND_W'(8'hFF) << op_sh))
                       | (OPERAND_W'(s_axis_tdata) << op_sh);
   // A pending echo byte still owns the output slot and goes out before the result.
   assign tx_fire      = (state_q == S_TX) && !out_valid_q && m_axis_tready;
   assign mul_start    = (state_q == S_OPERAND) && s_fire && op_last_byte && !first_q && is_mul;

   // Header verdict, evaluated while the len MSB is on the bus.
   always_comb begin
      hdr_err  = ERR_NONE;
      hdr_next = S_OP;
      if (len < HDR_LEN) begin
         hdr_err = ERR_LEN;
      end else if (opcode_q != OP_ECHO && opcode_q != OP_ADD && opcode_q != OP_MUL) begin
         hdr_err  = ERR_OPCODE;
         hdr_next = (payload == 16'd0) ? S_OP : S_DRAIN;
      end else if (opcode_q == OP_ECHO) begin
         hdr_next = (payload == 16'd0) ? S_OP : S_ECHO;
      end else if (payload == 16'd0 || (payload % 16'(NB)) != 16'd0) begin
         hdr_err  = ERR_LEN;
         hdr_next = (payload == 16'd0) ? S_OP : S_DRAIN;
      end else begin
         hdr_next = S_OPERAND;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= S_OP;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_OP:       if (s_fire) state_d = S_RSV;
         S_RSV:      if (s_fire) state_d = S_LEN_LO;
         S_LEN_LO:   if (s_fire) state_d = S_LEN_HI;
         S_LEN_HI:   if (s_fire) state_d = hdr_next;
         S_ECHO:     if (s_fire && pay_last) state_d = S_OP;
         S_OPERAND: begin
            if (s_fire && op_last_byte) begin
               if (!first_q && is_mul) state_d = S_MUL_WAIT;
               else if (pay_last)      state_d = S_TX;
            end
         end
         S_MUL_WAIT: if (mul_done) state_d = (cnt_q == 16'd0) ? S_TX : S_OPERAND;
         S_TX:       if (tx_fire && tx_idx_q == 4'(NB - 1)) state_d = S_OP;
         S_DRAIN:    if (s_fire && pay_last) state_d = S_OP;
         default:    state_d = S_OP;
      endcase
   end

   always_comb begin
      s_axis_tready = 1'b0;
      if (!reset_i) begin
         unique case (state_q)
            S_OP, S_RSV, S_LEN_LO, S_LEN_HI, S_OPERAND, S_DRAIN: s_axis_tready = 1'b1;
            S_ECHO:  s_axis_tready = !out_valid_q || m_axis_tready;
            default: s_axis_tready = 1'b0;
         endcase
      end
      m_axis_tvalid = out_valid_q || (state_q == S_TX);
      m_axis_tdata  = out_data_q;
      if (!out_valid_q && state_q == S_TX) m_axis_tdata = 8'(acc_q >> tx_sh);
      busy_o        = (state_q != S_OP);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         opcode_q    <= 8'd0;
         len_lo_q    <= 8'd0;
         cnt_q       <= 16'd0;
         byte_idx_q  <= 4'd0;
         tx_idx_q    <= 4'd0;
         op_q        <= '0;
         acc_q       <= '0;
         first_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'd0;
         err_q       <= 1'b0;
         err_code_q  <= ERR_NONE;
      end else begin
         err_q <= 1'b0;
         if (state_q == S_OP && s_fire)     opcode_q <= s_axis_tdata;
         if (state_q == S_LEN_LO && s_fire) len_lo_q <= s_axis_tdata;
         if (state_q == S_LEN_HI && s_fire) begin
            cnt_q      <= payload;
            byte_idx_q <= 4'd0;
            tx_idx_q   <= 4'd0;
            first_q    <= 1'b1;
            if (hdr_err != ERR_NONE) begin
               err_q      <= 1'b1;
               err_code_q <= hdr_err;
            end
         end
         if ((state_q == S_ECHO || state_q == S_OPERAND || state_q == S_DRAIN) && s_fire)
            cnt_q <= cnt_q - 16'd1;

         if (out_valid_q && m_axis_tready) out_valid_q <= 1'b0;
         if (state_q == S_ECHO && s_fire) begin
            out_valid_q <= 1'b1;
            out_data_q  <= s_axis_tdata;
         end

         if (state_q == S_OPERAND && s_fire) begin
            op_q <= op_asm;
            if (op_last_byte) begin
               byte_idx_q <= 4'd0;
               first_q    <= 1'b0;
               if (first_q)     acc_q <= op_asm;
               else if (!is_mul) acc_q <= acc_q + op_asm;
            end else begin
               byte_idx_q <= byte_idx_q + 4'd1;
            end
         end
         if (state_q == S_MUL_WAIT && mul_done) acc_q <= mul_p;
         if (tx_fire) tx_idx_q <= (tx_idx_q == 4'(NB - 1)) ? 4'd0 : tx_idx_q + 4'd1;
      end
   end

   assign err_o      = err_q;
   assign err_code_o = err_code_q;

   alu_mul_iter #(
      .OPERAND_W(OPERAND_W)
   ) u_mul (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .start_i(mul_start),
      .a_i    (acc_q),
      .b_i    (op_asm),
      .done_o (mul_done),
      .p_o    (mul_p)
   );

endmodule

// File: tb/tb_alu_packet_engine.sv
// Self-checking bench: directed packets plus random packets against a packet-level model.
module tb_alu_packet_engine;

   localparam int W = 32;

   logic       clk = 1'b0;
   logic       reset_i;
   logic [7:0] s_axis_tdata;
   logic       s_axis_tvalid;
   logic       s_axis_tready;
   logic [7:0] m_axis_tdata;
   logic       m_axis_tvalid;
   logic       m_axis_tready;
   logic       busy_o;
   logic       err_o;
   logic [1:0] err_code_o;

   always #5 clk = ~clk;

   alu_packet_engine #(
      .OPERAND_W(W)
   ) dut (
      .clk_i        (clk),
      .reset_i      (reset_i),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .busy_o       (busy_o),
      .err_o        (err_o),
      .err_code_o   (err_code_o)
   );

   int         errors = 0;
   int         checks = 0;
   int         err_pulses = 0;
   int         exp_pulse;
   logic [1:0] exp_code = 2'd0;
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] pkt[$];
   int         stalls[$];
   bit         rdy_rand = 1'b0;
   logic       stall_prev = 1'b0;
   logic [7:0] prev_data = 8'd0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output sink: random or constant back-pressure.
   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: collects TX bytes, counts error pulses, checks hold-while-stalled.
   always @(negedge clk) begin
      if (reset_i) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) check("tx_hold", {m_axis_tvalid, m_axis_tdata}, {1'b1, prev_data});
         if (m_axis_tvalid && m_axis_tready) rx_q.push_back(m_axis_tdata);
         if (err_o) err_pulses++;
         stall_prev = m_axis_tvalid && !m_axis_tready;
         prev_data  = m_axis_tdata;
      end
   end

   // Packet-level reference: what the TX stream and error outputs should show.
   function automatic void model(input logic [7:0] p[$]);
      int unsigned     len, n, k;
      longint unsigned acc, v;
      exp_q.delete();
      exp_pulse = 0;
      acc = 0;
      len = {p[3], p[2]};
      if (len < 4) begin
         exp_pulse = 1;
         exp_code  = 2'd2;
         return;
      end
      n = len - 4;
      if (p[0] != 8'hEC && p[0] != 8'hAD && p[0] != 8'h88) begin
         exp_pulse = 1;
         exp_code  = 2'd1;
      end else if (p[0] == 8'hEC) begin
         for (int i = 0; i < int'(n); i++) exp_q.push_back(p[4 + i]);
      end else if (n == 0 || (n % 4) != 0) begin
         exp_pulse = 1;
         exp_code  = 2'd2;
      end else begin
         for (k = 0; k < n / 4; k++) begin
            v = {32'd0, p[4 + 4 * k + 3], p[4 + 4 * k + 2], p[4 + 4 * k + 1], p[4 + 4 * k]};
            if (k == 0)            acc = v;
            else if (p[0] == 8'hAD) acc = (acc + v) & 64'hFFFF_FFFF;
            else                    acc = (acc * v) & 64'hFFFF_FFFF;
         end
         for (int b = 0; b < 4; b++) exp_q.push_back(8'(acc >> (8 * b)));
      end
   endfunction

   // Called at posedge+1; returns at posedge+1 after the last byte is accepted.
   task automatic send_bytes(input logic [7:0] p[$]);
      int st;
      stalls.delete();
      foreach (p[i]) begin
         s_axis_tdata  = p[i];
         s_axis_tvalid = 1'b1;
         st = 0;
         forever begin
            @(negedge clk);
            if (s_axis_tready) break;
            st++;
            if (st > 2000) begin
               check("send_timeout", s_axis_tready, 1);
               break;
            end
         end
         @(posedge clk);
         #1;
         stalls.push_back(st);
      end
      s_axis_tvalid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy_o || m_axis_tvalid) && n < 5000);
      if (n >= 5000) check("idle_timeout", busy_o | m_axis_tvalid, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic compare(input string tag, input int pulses0);
      check({tag, "_len"}, rx_q.size(), exp_q.size());
      foreach (exp_q[i]) if (i < rx_q.size()) check({tag, "_byte"}, rx_q[i], exp_q[i]);
      check({tag, "_errpulse"}, err_pulses - pulses0, exp_pulse);
      check({tag, "_errcode"}, err_code_o, exp_code);
      check({tag, "_busy"}, busy_o, 0);
   endtask

   task automatic run_pkt(input string tag);
      int p0 = err_pulses;
      model(pkt);
      rx_q.delete();
      send_bytes(pkt);
      wait_idle();
      compare(tag, p0);
   endtask

   task automatic build(input logic [7:0] op, input int npay);
      logic [15:0] len = 16'(4 + npay);
      pkt.delete();
      pkt.push_back(op);
      pkt.push_back(8'($urandom));
      pkt.push_back(len[7:0]);
      pkt.push_back(len[15:8]);
      for (int i = 0; i < npay; i++) pkt.push_back(8'($urandom));
   endtask

   task automatic gen_random();
      int          kind = $urandom_range(0, 9);
      logic [7:0]  op;
      logic [15:0] len;
      int          bad_n[10] = '{0, 1, 2, 3, 5, 6, 7, 9, 10, 11};
      case (kind)
         0: begin
            len = 16'($urandom_range(0, 3));
            pkt = {8'($urandom), 8'($urandom), len[7:0], len[15:8]};
         end
         1: begin
            do op = 8'($urandom); while (op == 8'hEC || op == 8'hAD || op == 8'h88);
            build(op, $urandom_range(0, 8));
         end
         4, 5:    build(8'hAD, 4 * $urandom_range(1, 4));
         6, 7:    build(8'h88, 4 * $urandom_range(1, 3));
         8:       build($urandom_range(0, 1) ? 8'hAD : 8'h88, bad_n[$urandom_range(0, 9)]);
         default: build(8'hEC, $urandom_range(0, 20));
      endcase
   endtask

   initial begin
      int n;
      int p0;
      reset_i       = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_s_tready", s_axis_tready, 0);
      check("rst_m_tvalid", m_axis_tvalid, 0);
      check("rst_m_tdata", m_axis_tdata, 0);
      check("rst_busy", busy_o, 0);
      check("rst_err", {err_o, err_code_o}, 0);
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      @(negedge clk);
      check("idle_s_tready", s_axis_tready, 1);
      @(posedge clk);
      #1;

      // Echo: one-cycle latency, full throughput.
      pkt = {8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
      model(pkt);
      p0 = err_pulses;
      rx_q.delete();
      send_bytes(pkt);
      check("echo_inflight", rx_q.size(), 2);
      @(negedge clk);
      check("echo_last_out", {m_axis_tvalid, m_axis_tdata}, {1'b1, 8'h43});
      wait_idle();
      compare("echo", p0);

      // Wrapping sum, result valid right after last operand byte.
      pkt = {8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
             8'hFF, 8'hFF, 8'hFF, 8'hFF};
      model(pkt);
      check("add_model", {exp_q[0], exp_q[1], exp_q[2], exp_q[3]}, 0);
      p0 = err_pulses;
      rx_q.delete();
      send_bytes(pkt);
      @(negedge clk);
      check("add_latency", m_axis_tvalid, 1);
      wait_idle();
      compare("add_wrap", p0);

      // Product 3*5*7 with multiplier hold-off.
      pkt = {8'h88, 8'h00, 8'h10, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
             8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
      model(pkt);
      p0 = err_pulses;
      rx_q.delete();
      send_bytes(pkt);
      n = 0;
      forever begin
         @(negedge clk);
         if (m_axis_tvalid || n > 200) break;
         n++;
      end
      check("mul_tx_latency", n, 32);
      check("mul_stall_op2", stalls[8], 0);
      check("mul_stall_op3", stalls[12], 32);
      check("mul_stall_mid", stalls[13], 0);
      wait_idle();
      compare("mul", p0);
      check("mul_result", rx_q[0], 8'h69);

      // Bad length: error pulse right after the len MSB, payload drained.
      pkt = {8'hAD, 8'h00, 8'h09, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      model(pkt);
      p0 = err_pulses;
      rx_q.delete();
      send_bytes(pkt[0:3]);
      @(negedge clk);
      check("badlen_err_pulse", {err_o, err_code_o}, {1'b1, 2'd2});
      check("badlen_draining", {busy_o, s_axis_tready}, 2'b11);
      @(posedge clk);
      #1;
      send_bytes(pkt[4:8]);
      wait_idle();
      compare("badlen", p0);
      build(8'hAD, 8);
      run_pkt("after_badlen");

      // Echo under random back-pressure.
      rdy_rand = 1'b1;
      build(8'hEC, 40);
      run_pkt("echo_stall");

      // Reset in the middle of an echo payload.
      build(8'hEC, 60);
      send_bytes(pkt[0:23]);
      reset_i = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_tvalid", m_axis_tvalid, 0);
      check("midrst_busy", busy_o, 0);
      check("midrst_tready", s_axis_tready, 0);
      check("midrst_errcode", err_code_o, 0);
      reset_i  = 1'b0;
      rdy_rand = 1'b0;
      exp_code = 2'd0;
      @(posedge clk);
      #1;
      build(8'h88, 8);
      run_pkt("after_reset");

      for (int i = 0; i < 40; i++) begin
         rdy_rand = (i % 3) == 1;
         gen_random();
         run_pkt("rand");
      end
      rdy_rand = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
